// File: rtl/rf_operand_fetch.sv
// rtl/rf_operand_fetch.sv - operand-fetch stage with 32-entry write scoreboard in front of register_file
//
// Ports:
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   instr_valid_i / instr_ready_o      decoded instruction handshake (ready only in IDLE)
//   rs1/rs2_addr_i, rs1/rs2_en_i       source registers and their use flags
//   rd_addr_i, rd_we_i                 destination register and write flag
//   req_ra_o/req_rb_o, raddr_a/b_o     registered read strobes and addresses to register_file
//   rdata_a_i, rdata_b_i               register_file read data, captured at the REQ exit edge
//   wb_valid_i, wb_addr_i              writeback retiring a pending register
//   op_valid_o / op_ready_i            operand handshake to execute
//   op_a_o, op_b_o, op_rd_*_o          operands and forwarded destination
//   wb_err_o                           sticky: writeback hit a clear scoreboard bit or x0
module rf_operand_fetch #(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic [4:0]           rs1_addr_i,
    input  logic [4:0]           rs2_addr_i,
    input  logic                 rs1_en_i,
    input  logic                 rs2_en_i,
    input  logic [4:0]           rd_addr_i,
    input  logic                 rd_we_i,
    output logic                 req_ra_o,
    output logic                 req_rb_o,
    output logic [4:0]           raddr_a_o,
    output logic [4:0]           raddr_b_o,
    input  logic [DataWidth-1:0] rdata_a_i,
    input  logic [DataWidth-1:0] rdata_b_i,
    input  logic                 wb_valid_i,
    input  logic [4:0]           wb_addr_i,
    output logic                 op_valid_o,
    input  logic                 op_ready_i,
    output logic [DataWidth-1:0] op_a_o,
    output logic [DataWidth-1:0] op_b_o,
    output logic [4:0]           op_rd_addr_o,
    output logic                 op_rd_we_o,
    output logic                 wb_err_o
);

    typedef enum logic [1:0] {IDLE, HAZ, REQ, OUT} state_t;

    state_t      state;
    logic [31:0] scoreboard;
    logic        rs1_act_q;
    logic        rs2_act_q;

    logic        rs1_act_in;
    logic        rs2_act_in;
    logic        haz_in;
    logic        haz_q;
    logic        handshake;
    logic [31:0] sb_next;
    logic        err_set;

    assign instr_ready_o = (state == IDLE);

    // x0 is hardwired, so a source naming it never needs a read or a hazard check.
    assign rs1_act_in = rs1_en_i && (rs1_addr_i != 5'd0);
    assign rs2_act_in = rs2_en_i && (rs2_addr_i != 5'd0);

    // Both checks look at the scoreboard as it stands now; a clear landing on this
    // same edge only unblocks the instruction on the following cycle.
    assign haz_in = (rs1_act_in && scoreboard[rs1_addr_i]) ||
                    (rs2_act_in && scoreboard[rs2_addr_i]);
    assign haz_q  = (rs1_act_q && scoreboard[raddr_a_o]) ||
                    (rs2_act_q && scoreboard[raddr_b_o]);

    assign handshake = (state == OUT) && op_ready_i;

    // Clear first, then set, so a retire and a new claim of the same register on one
    // edge leaves the register pending.
    always_comb begin
        sb_next = scoreboard;
        err_set = 1'b0;
        if (wb_valid_i) begin
            if ((wb_addr_i != 5'd0) && scoreboard[wb_addr_i]) begin
                sb_next[wb_addr_i] = 1'b0;
            end else begin
                err_set = 1'b1;
            end
        end
        if (handshake && op_rd_we_o && (op_rd_addr_o != 5'd0)) begin
            sb_next[op_rd_addr_o] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= IDLE;
            scoreboard   <= '0;
            rs1_act_q    <= 1'b0;
            rs2_act_q    <= 1'b0;
            req_ra_o     <= 1'b0;
            req_rb_o     <= 1'b0;
            raddr_a_o    <= '0;
            raddr_b_o    <= '0;
            op_valid_o   <= 1'b0;
            op_a_o       <= '0;
            op_b_o       <= '0;
            op_rd_addr_o <= '0;
            op_rd_we_o   <= 1'b0;
            wb_err_o     <= 1'b0;
        end else begin
            scoreboard <= sb_next;
            if (err_set) begin
                wb_err_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (instr_valid_i) begin
                        raddr_a_o    <= rs1_addr_i;
                        raddr_b_o    <= rs2_addr_i;
                        rs1_act_q    <= rs1_act_in;
                        rs2_act_q    <= rs2_act_in;
                        op_rd_addr_o <= rd_addr_i;
                        op_rd_we_o   <= rd_we_i;
                        if (haz_in) begin
                            state <= HAZ;
                        end else begin
                            state    <= REQ;
                            req_ra_o <= rs1_act_in;
                            req_rb_o <= rs2_act_in;
                        end
                    end
                end
                HAZ: begin
                    if (!haz_q) begin
                        state    <= REQ;
                        req_ra_o <= rs1_act_q;
                        req_rb_o <= rs2_act_q;
                    end
                end
                REQ: begin
                    // Entered even with no active source so latency is always fixed.
                    req_ra_o   <= 1'b0;
                    req_rb_o   <= 1'b0;
                    op_a_o     <= rs1_act_q ? rdata_a_i : '0;
                    op_b_o     <= rs2_act_q ? rdata_b_i : '0;
                    op_valid_o <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    if (op_ready_i) begin
                        op_valid_o <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_operand_fetch.sv
// tb/tb_rf_operand_fetch.sv - self-checking bench for rf_operand_fetch
module tb_rf_operand_fetch;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic [4:0]  rs1_addr_i = '0;
    logic [4:0]  rs2_addr_i = '0;
    logic        rs1_en_i = 1'b0;
    logic        rs2_en_i = 1'b0;
    logic [4:0]  rd_addr_i = '0;
    logic        rd_we_i = 1'b0;
    logic        req_ra_o;
    logic        req_rb_o;
    logic [4:0]  raddr_a_o;
    logic [4:0]  raddr_b_o;
    logic [31:0] rdata_a_i;
    logic [31:0] rdata_b_i;
    logic        wb_valid_i = 1'b0;
    logic [4:0]  wb_addr_i = '0;
    logic [31:0] wb_data = '0;
    logic        op_valid_o;
    logic        op_ready_i = 1'b0;
    logic [31:0] op_a_o;
    logic [31:0] op_b_o;
    logic [4:0]  op_rd_addr_o;
    logic        op_rd_we_o;
    logic        wb_err_o;

    // Behavioural register file (asynchronous read) and pending-write set.
    logic [31:0] regs [32];
    logic [31:0] exp_sb;
    logic        exp_err;
    int          n_cmp;
    int          n_err;

    assign rdata_a_i = regs[raddr_a_o];
    assign rdata_b_i = regs[raddr_b_o];

    always #5 clk_i = ~clk_i;

    rf_operand_fetch #(.DataWidth(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_en_i(rs1_en_i), .rs2_en_i(rs2_en_i),
        .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
        .req_ra_o(req_ra_o), .req_rb_o(req_rb_o),
        .raddr_a_o(raddr_a_o), .raddr_b_o(raddr_b_o),
        .rdata_a_i(rdata_a_i), .rdata_b_i(rdata_b_i),
        .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i),
        .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
        .op_a_o(op_a_o), .op_b_o(op_b_o),
        .op_rd_addr_o(op_rd_addr_o), .op_rd_we_o(op_rd_we_o),
        .wb_err_o(wb_err_o)
    );

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        en1;
        logic        en2;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  exp_str;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock; applies the register-file write and the pending-set rules to the model.
    task automatic tick(input bit set_en, input logic [4:0] set_addr);
        bit          do_wb;
        logic [4:0]  a;
        logic [31:0] d;
        do_wb = wb_valid_i;
        a = wb_addr_i;
        d = wb_data;
        @(posedge clk_i);
        #1;
        if (do_wb && rst_ni) begin
            if (a != 5'd0) regs[a] = d;
            if (a != 5'd0 && exp_sb[a]) exp_sb[a] = 1'b0;
            else exp_err = 1'b1;
        end
        if (set_en && rst_ni && set_addr != 5'd0) exp_sb[set_addr] = 1'b1;
        wb_valid_i = 1'b0;
    endtask

    task automatic run_instr(input vec_t v, input bit use_exp, input int hold,
                             input bit hs_wb, input logic [4:0] hs_wb_addr);
        logic        a1;
        logic        a2;
        logic [31:0] xa;
        logic [31:0] xb;
        logic [4:0]  blk[$];
        a1 = v.en1 && v.rs1 != 5'd0;
        a2 = v.en2 && v.rs2 != 5'd0;
        if (a1 && exp_sb[v.rs1]) blk.push_back(v.rs1);
        if (a2 && exp_sb[v.rs2] && !(a1 && v.rs1 == v.rs2)) blk.push_back(v.rs2);
        chk("ready_idle", 32'(instr_ready_o), 32'd1);
        rs1_addr_i = v.rs1; rs2_addr_i = v.rs2;
        rs1_en_i = v.en1;   rs2_en_i = v.en2;
        rd_addr_i = v.rd;   rd_we_i = v.we;
        instr_valid_i = 1'b1;
        tick(1'b0, 5'd0);
        instr_valid_i = 1'b0;
        chk("ready_busy", 32'(instr_ready_o), 32'd0);
        if (blk.size() != 0) begin
            chk("stall_strobe", 32'({req_ra_o, req_rb_o}), 32'd0);
            repeat (2) begin
                tick(1'b0, 5'd0);
                chk("stall_strobe", 32'({req_ra_o, req_rb_o}), 32'd0);
                chk("stall_ready", 32'(instr_ready_o), 32'd0);
            end
            foreach (blk[i]) begin
                wb_valid_i = 1'b1; wb_addr_i = blk[i]; wb_data = $urandom;
                tick(1'b0, 5'd0);
                chk("wb_edge_strobe", 32'({req_ra_o, req_rb_o}), 32'd0);
            end
            tick(1'b0, 5'd0);
        end
        chk("strobe", 32'({req_ra_o, req_rb_o}), 32'(v.exp_str));
        if (a1) chk("raddr_a", 32'(raddr_a_o), 32'(v.rs1));
        if (a2) chk("raddr_b", 32'(raddr_b_o), 32'(v.rs2));
        chk("valid_early", 32'(op_valid_o), 32'd0);
        xa = use_exp ? v.exp_a : (a1 ? regs[v.rs1] : 32'd0);
        xb = use_exp ? v.exp_b : (a2 ? regs[v.rs2] : 32'd0);
        tick(1'b0, 5'd0);
        chk("strobe_drop", 32'({req_ra_o, req_rb_o}), 32'd0);
        chk("op_valid", 32'(op_valid_o), 32'd1);
        chk("op_a", op_a_o, xa);
        chk("op_b", op_b_o, xb);
        chk("op_rd_addr", 32'(op_rd_addr_o), 32'(v.rd));
        chk("op_rd_we", 32'(op_rd_we_o), 32'(v.we));
        for (int i = 0; i < hold; i++) begin
            tick(1'b0, 5'd0);
            chk("bp_valid", 32'(op_valid_o), 32'd1);
            chk("bp_op_a", op_a_o, xa);
            chk("bp_op_b", op_b_o, xb);
            chk("bp_rd", 32'(op_rd_addr_o), 32'(v.rd));
            chk("bp_ready", 32'(instr_ready_o), 32'd0);
            chk("bp_sb", dut.scoreboard, exp_sb);
        end
        if (hs_wb) begin
            wb_valid_i = 1'b1; wb_addr_i = hs_wb_addr; wb_data = $urandom;
        end
        op_ready_i = 1'b1;
        tick(v.we, v.rd);
        op_ready_i = 1'b0;
        chk("valid_after_hs", 32'(op_valid_o), 32'd0);
        chk("ready_after_hs", 32'(instr_ready_o), 32'd1);
        chk("sb_after_hs", dut.scoreboard, exp_sb);
    endtask

    vec_t tbl[5];

    initial begin
        vec_t        v;
        logic [4:0]  pend[$];
        n_cmp = 0;
        n_err = 0;
        exp_sb = '0;
        exp_err = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : (32'h1000_0000 | 32'(i));
        regs[5] = 32'h11;
        regs[6] = 32'h22;

        //              rs1    rs2    en1   en2   rd     we    str    exp_a         exp_b
        tbl[0] = '{5'd5,  5'd6,  1'b1, 1'b1, 5'd7, 1'b1, 2'b11, 32'h11,       32'h22};
        tbl[1] = '{5'd0,  5'd9,  1'b1, 1'b0, 5'd0, 1'b1, 2'b00, 32'h0,        32'h0};
        tbl[2] = '{5'd10, 5'd0,  1'b1, 1'b1, 5'd3, 1'b0, 2'b10, 32'h1000000A, 32'h0};
        tbl[3] = '{5'd12, 5'd12, 1'b0, 1'b1, 5'd4, 1'b0, 2'b01, 32'h0,        32'h1000000C};
        tbl[4] = '{5'd31, 5'd1,  1'b1, 1'b1, 5'd0, 1'b0, 2'b11, 32'h1000001F, 32'h10000001};

        repeat (2) tick(1'b0, 5'd0);
        chk("rst_ready", 32'(instr_ready_o), 32'd1);
        chk("rst_strobe", 32'({req_ra_o, req_rb_o}), 32'd0);
        chk("rst_raddr", 32'({raddr_a_o, raddr_b_o}), 32'd0);
        chk("rst_valid", 32'(op_valid_o), 32'd0);
        chk("rst_op_a", op_a_o, 32'd0);
        chk("rst_op_b", op_b_o, 32'd0);
        chk("rst_rd", 32'({op_rd_addr_o, op_rd_we_o}), 32'd0);
        chk("rst_err", 32'(wb_err_o), 32'd0);
        chk("rst_sb", dut.scoreboard, 32'd0);
        rst_ni = 1'b1;
        tick(1'b0, 5'd0);

        for (int i = 0; i < 5; i++) run_instr(tbl[i], 1'b1, 0, 1'b0, 5'd0);
        chk("sb7_pending", dut.scoreboard, 32'h0000_0080);

        // Hazard stall on x7, released by a writeback of 0xAB.
        rs1_addr_i = 5'd7; rs1_en_i = 1'b1; rs2_addr_i = 5'd0; rs2_en_i = 1'b0;
        rd_addr_i = 5'd8; rd_we_i = 1'b0; instr_valid_i = 1'b1;
        tick(1'b0, 5'd0);
        instr_valid_i = 1'b0;
        repeat (3) begin
            chk("haz_strobe", 32'({req_ra_o, req_rb_o}), 32'd0);
            chk("haz_ready", 32'(instr_ready_o), 32'd0);
            tick(1'b0, 5'd0);
        end
        wb_valid_i = 1'b1; wb_addr_i = 5'd7; wb_data = 32'hAB;
        tick(1'b0, 5'd0);
        chk("haz_ew_strobe", 32'({req_ra_o, req_rb_o}), 32'd0);
        tick(1'b0, 5'd0);
        chk("haz_ew1_strobe", 32'({req_ra_o, req_rb_o}), 32'b10);
        chk("haz_ew1_valid", 32'(op_valid_o), 32'd0);
        tick(1'b0, 5'd0);
        chk("haz_ew2_valid", 32'(op_valid_o), 32'd1);
        chk("haz_op_a", op_a_o, 32'hAB);
        chk("haz_op_b", op_b_o, 32'h0);
        op_ready_i = 1'b1;
        tick(1'b0, 5'd0);
        op_ready_i = 1'b0;
        chk("haz_sb", dut.scoreboard, exp_sb);

        // Backpressure: five cycles without ready in OUT.
        v = '{5'd5, 5'd6, 1'b1, 1'b1, 5'd12, 1'b1, 2'b11, 32'h11, 32'h22};
        run_instr(v, 1'b1, 5, 1'b0, 5'd0);

        // Set and clear of x9 on the same edge: set wins.
        v = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 2'b00, 32'h0, 32'h0};
        run_instr(v, 1'b1, 0, 1'b0, 5'd0);
        run_instr(v, 1'b1, 0, 1'b1, 5'd9);
        chk("setclr_sb9", 32'(dut.scoreboard[9]), 32'd1);
        chk("setclr_err", 32'(wb_err_o), 32'd0);
        wb_valid_i = 1'b1; wb_addr_i = 5'd3; wb_data = 32'h33;
        tick(1'b0, 5'd0);
        chk("wb_clear_err", 32'(wb_err_o), 32'(exp_err));
        chk("wb_clear_err_set", 32'(wb_err_o), 32'd1);
        tick(1'b0, 5'd0);
        chk("err_sticky", 32'(wb_err_o), 32'd1);
        chk("sb_unchanged", dut.scoreboard, exp_sb);

        // Reset while in REQ.
        rs1_addr_i = 5'd5; rs1_en_i = 1'b1; rs2_addr_i = 5'd6; rs2_en_i = 1'b1;
        rd_addr_i = 5'd14; rd_we_i = 1'b1; instr_valid_i = 1'b1;
        tick(1'b0, 5'd0);
        instr_valid_i = 1'b0;
        chk("req_strobe", 32'({req_ra_o, req_rb_o}), 32'b11);
        rst_ni = 1'b0;
        tick(1'b0, 5'd0);
        chk("mrst_strobe", 32'({req_ra_o, req_rb_o}), 32'd0);
        chk("mrst_valid", 32'(op_valid_o), 32'd0);
        chk("mrst_sb", dut.scoreboard, 32'd0);
        chk("mrst_err", 32'(wb_err_o), 32'd0);
        chk("mrst_op_a", op_a_o, 32'd0);
        rst_ni = 1'b1;
        exp_sb = '0;
        exp_err = 1'b0;
        chk("mrst_ready", 32'(instr_ready_o), 32'd1);
        tick(1'b0, 5'd0);

        // Random instructions against the model, with occasional retires of pending writes.
        for (int n = 0; n < 40; n++) begin
            v.rs1 = 5'($urandom_range(0, 31));
            v.rs2 = 5'($urandom_range(0, 31));
            v.en1 = 1'($urandom_range(0, 1));
            v.en2 = 1'($urandom_range(0, 1));
            v.rd  = 5'($urandom_range(0, 31));
            v.we  = 1'($urandom_range(0, 1));
            v.exp_str = {v.en1 && v.rs1 != 5'd0, v.en2 && v.rs2 != 5'd0};
            v.exp_a = '0;
            v.exp_b = '0;
            run_instr(v, 1'b0, $urandom_range(0, 2), 1'b0, 5'd0);
            if ($urandom_range(0, 1) == 1) begin
                pend.delete();
                for (int r = 1; r < 32; r++) if (exp_sb[r]) pend.push_back(5'(r));
                if (pend.size() != 0) begin
                    wb_valid_i = 1'b1;
                    wb_addr_i = pend[$urandom_range(0, pend.size() - 1)];
                    wb_data = $urandom;
                    tick(1'b0, 5'd0);
                end
            end
        end
        chk("final_sb", dut.scoreboard, exp_sb);
        chk("final_err", 32'(wb_err_o), 32'(exp_err));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_operand_fetch.md
# rf_operand_fetch

Operand-fetch stage directly upstream of `register_file`. It accepts one decoded instruction at a time and tracks outstanding register writes in a 32-entry scoreboard. It drives glitch-free registered read strobes (`req_ra`/`req_rb`) into the register file, captures the returned operands, and hands them to the execute stage over a valid/ready handshake.

## Interface
- `DataWidth`, 32, operand width; must match `register_file`.

- `clk_i`  in  1  clock
- `rst_ni`  in  1  synchronous active-low reset
- `instr_valid_i`  in  1  decoded instruction present
- `instr_ready_o`  out  1  stage can accept an instruction
- `rs1_addr_i`, `rs2_addr_i`  in  5  source register addresses
- `rs1_en_i`, `rs2_en_i`  in  1  source operand used
- `rd_addr_i`  in  5  destination register
- `rd_we_i`  in  1  instruction writes `rd`
- `req_ra_o`, `req_rb_o`  out  1  register-file read strobes; the register file samples on the rising edge
- `raddr_a_o`, `raddr_b_o`  out  5  register-file read addresses
- `rdata_a_i`, `rdata_b_i`  in  DataWidth  register-file read data
- `wb_valid_i`  in  1  writeback retires a register write this cycle
- `wb_addr_i`  in  5  writeback destination
- `op_valid_o`  out  1  operands valid
- `op_ready_i`  in  1  execute stage accepts operands
- `op_a_o`, `op_b_o`  out  DataWidth  operands
- `op_rd_addr_o`  out  5  forwarded destination
- `op_rd_we_o`  out  1  forwarded write enable
- `wb_err_o`  out  1  sticky flag: writeback hit a register whose scoreboard bit was clear

## Operation
- FSM states: IDLE, HAZ, REQ, OUT.
- `instr_ready_o` = (state == IDLE), combinational.
- A source is active when `rsN_en` is 1 and `rsN_addr` != 0.
- A hazard exists when an active source has its scoreboard bit set.
- The hazard check uses the current scoreboard, before any clear occurring on the same edge.
- **IDLE:** on `instr_valid_i`, register all instruction fields.
  - Hazard present: go to HAZ.
  - No hazard: go to REQ. On that same edge, set `req_ra_o` if rs1 is active and `req_rb_o` if rs2 is active.
- **HAZ:** re-evaluate the hazard each cycle on the registered fields. When the hazard is clear, go to REQ and set the strobes as above.
- **REQ:** lasts exactly one cycle.
  - At the exit edge, drop both strobes.
  - Latch `op_a_o` from `rdata_a_i` if rs1 is active, else 0. Latch `op_b_o` from `rdata_b_i` if rs2 is active, else 0.
  - Go to OUT.
  - REQ is entered even when neither source is active, so latency stays fixed.
- **OUT:** `op_valid_o` = 1. All `op_*` outputs are held stable until `op_valid_o && op_ready_i`. On that edge, go to IDLE and set `scoreboard[rd]` if `rd_we` is 1 and `rd` != 0.
- **Scoreboard:**
  - `wb_valid_i` clears `scoreboard[wb_addr_i]`.
  - If the same edge both sets and clears one bit, set wins.
  - Bit 0 is never set.
  - A writeback to a clear bit, or to address 0, leaves the scoreboard unchanged and sets `wb_err_o`.
- `raddr_a_o` and `raddr_b_o` are registered and driven from the registered rs1/rs2 fields. They are stable whenever a strobe is high.
- The register file completes a write on the clock edge where `wb_valid_i` is sampled.

## Timing
- **Reset:** state IDLE, scoreboard all 0, and the following outputs are 0: `req_ra_o`, `req_rb_o`, `raddr_*`, `op_valid_o`, `op_a_o`, `op_b_o`, `op_rd_addr_o`, `op_rd_we_o`, `wb_err_o`.
  - Reset mid-operation aborts the instruction and drops the strobes on that edge.
  - Operands are not delivered and the scoreboard is not updated.
- **Latency without hazard:** accept at edge E0; strobes high from E0 to E1; `op_valid_o` high after E1.
- **Throughput:** at most one instruction every 3 cycles (IDLE, REQ, OUT).
- **Latency with hazard:** a writeback clearing the blocking bit at edge Ew gives strobes rising at Ew+1 and `op_valid_o` rising at Ew+2.
- **Strobe shape:** each strobe is a flop output. Every rising edge aligns with `clk_i`, and each pulse is exactly one cycle wide.

## Test plan
- **No hazard:** reset; preload x5=0x11, x6=0x22; issue rs1=5, rs2=6, rd=7, rd_we=1 at E0.
  - Required: `req_ra_o`/`req_rb_o` high only in cycle E0–E1.
  - Required: `op_valid_o` after E1 with `op_a_o`=0x11, `op_b_o`=0x22.
  - Required: `scoreboard[7]`=1 after the handshake.
- **Zero/disabled sources:** issue rs1=0, rs2_en=0.
  - Required: no strobe pulses.
  - Required: `op_a_o`=`op_b_o`=0.
  - Required: `op_valid_o` still appears 2 edges after accept.
- **Hazard stall:** x7 pending; issue rs1=7.
  - Required: stays in HAZ, `instr_ready_o`=0, no strobe.
  - Then `wb_valid_i`=1 with `wb_addr_i`=7 at Ew, writing 0xAB. Required: strobe rises at Ew+1 and `op_a_o`=0xAB.
- **Backpressure:** hold `op_ready_i`=0 for 5 cycles in OUT.
  - Required: outputs stable, `instr_ready_o`=0, scoreboard unchanged until the handshake.
- **Simultaneous set/clear:** x9 pending; handshake an instruction with rd=9, rd_we=1 on the same edge as a writeback to 9.
  - Required: `scoreboard[9]` remains 1.
  - Also: a writeback to x3 while its bit is clear must set `wb_err_o`=1.
- **Reset mid-operation:** assert `rst_ni`=0 during REQ.
  - Required: next cycle strobes are 0, `op_valid_o`=0, scoreboard is 0, and `instr_ready_o`=1 after release.
